// File: rtl/rv32i_multicycle_core.sv
// Multicycle RV32I-subset core (lw/sw/R-ALU/I-ALU/beq/bne/jal) sharing one instruction/data memory port.
// Latency: beq/bne 3, R/I/jal/sw 4, lw 5 cycles with zero-wait memory; each wait cycle adds one.
// Backpressure: mem_req held with stable addr/we/wdata until mem_ready; the FSM stalls in place meanwhile.

module register_file (
  input  logic        clk,
  input  logic [4:0]  a1,
  input  logic [4:0]  a2,
  input  logic [4:0]  a3,
  input  logic        we3,
  input  logic [31:0] wd3,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] regs [0:31];

  // Synchronous write; x0 is never written so it stays architecturally zero.
  always_ff @(posedge clk) begin
    if (we3 && (a3 != 5'd0)) regs[a3] <= wd3;
  end

  assign rd1 = (a1 == 5'd0) ? 32'd0 : regs[a1];
  assign rd2 = (a2 == 5'd0) ? 32'd0 : regs[a2];
endmodule

module extend (
  input  logic [31:7] instr,
  input  logic [1:0]  imm_src,
  output logic [31:0] imm
);
  // Sign-extended immediate for I (00), S (01), B (10) and J (11) formats.
  always_comb begin
    imm = 32'd0;
    case (imm_src)
      2'b00:   imm = {{20{instr[31]}}, instr[31:20]};
      2'b01:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      2'b10:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      default: imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endcase
  end
endmodule

module alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  ctl,
  output logic [31:0] y,
  output logic        zero
);
  // 32-bit operations, all wrapping modulo 2^32; slt is signed.
  always_comb begin
    y = 32'd0;
    case (ctl)
      3'b000:  y = a + b;
      3'b001:  y = a - b;
      3'b010:  y = a & b;
      3'b011:  y = a | b;
      3'b101:  y = {31'd0, ($signed(a) < $signed(b))};
      default: y = 32'd0;
    endcase
  end

  assign zero = (y == 32'd0);
endmodule

module rv32i_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic        retire,
  output logic        halted
);
  typedef enum logic [3:0] {
    S_BOOT, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BRANCH, S_HALT
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t      state, next_state;
  logic [31:0] ir, old_pc, a, b, alu_out, data;
  logic [31:0] rd1, rd2, imm_ext, alu_b, alu_y, wd3;
  logic [1:0]  imm_src;
  logic [2:0]  alu_ctl, f3_ctl;
  logic        alu_zero, legal, taken, reg_we, alu_src_reg;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1, rs2, rd;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign rd     = ir[11:7];

  // Writeback source is Data only for loads; everything else writes ALUOut.
  assign wd3 = (state == S_MEMWB) ? data : alu_out;

  register_file u_rf (
    .clk (clk),
    .a1  (rs1),
    .a2  (rs2),
    .a3  (rd),
    .we3 (reg_we && (rd != 5'd0)),
    .wd3 (wd3),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  extend u_ext (
    .instr   (ir[31:7]),
    .imm_src (imm_src),
    .imm     (imm_ext)
  );

  assign alu_b = alu_src_reg ? b : imm_ext;

  alu u_alu (
    .a    (a),
    .b    (alu_b),
    .ctl  (alu_ctl),
    .y    (alu_y),
    .zero (alu_zero)
  );

  assign taken = ((funct3 == 3'b000) && alu_zero) || ((funct3 == 3'b001) && !alu_zero);

  // Encoding legality check for the supported subset; anything else halts the core.
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_LW, OP_SW: legal = (funct3 == 3'b010);
      OP_R:         legal = ((funct7 == 7'h00) || (funct7 == 7'h20)) &&
                            (funct3 inside {3'b000, 3'b010, 3'b110, 3'b111});
      OP_I:         legal = (funct3 inside {3'b000, 3'b010, 3'b110, 3'b111});
      OP_BR:        legal = (funct3 == 3'b000) || (funct3 == 3'b001);
      OP_JAL:       legal = 1'b1;
      default:      legal = 1'b0;
    endcase
  end

  // Map funct3 onto the ALU operation shared by R-type and I-type arithmetic.
  always_comb begin
    f3_ctl = ALU_ADD;
    case (funct3)
      3'b010:  f3_ctl = ALU_SLT;
      3'b110:  f3_ctl = ALU_OR;
      3'b111:  f3_ctl = ALU_AND;
      default: f3_ctl = ALU_ADD;
    endcase
  end

  // State register; async reset parks the core in BOOT, which also drops any pending request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_BOOT;
    else       state <= next_state;
  end

  // Next-state logic plus Moore memory-port and datapath controls.
  always_comb begin
    next_state  = state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = alu_out;
    mem_wdata   = b;
    retire      = 1'b0;
    halted      = 1'b0;
    imm_src     = IMM_I;
    alu_ctl     = ALU_ADD;
    alu_src_reg = 1'b0;
    reg_we      = 1'b0;
    case (state)
      S_BOOT:   next_state = S_FETCH;
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (mem_ready) next_state = S_DECODE;
      end
      S_DECODE: begin
        imm_src = (opcode == OP_JAL) ? IMM_J : IMM_B;
        if (!legal) next_state = S_HALT;
        else begin
          case (opcode)
            OP_LW, OP_SW: next_state = S_MEMADR;
            OP_R:         next_state = S_EXECR;
            OP_I:         next_state = S_EXECI;
            OP_JAL:       next_state = S_JAL;
            OP_BR:        next_state = S_BRANCH;
            default:      next_state = S_HALT;
          endcase
        end
      end
      S_MEMADR: begin
        imm_src    = (opcode == OP_SW) ? IMM_S : IMM_I;
        next_state = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        if (mem_ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        reg_we     = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_EXECR: begin
        alu_src_reg = 1'b1;
        alu_ctl     = ((funct3 == 3'b000) && funct7[5]) ? ALU_SUB : f3_ctl;
        next_state  = S_ALUWB;
      end
      S_EXECI: begin
        alu_ctl    = f3_ctl;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_we     = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_JAL:    next_state = S_ALUWB;
      S_BRANCH: begin
        alu_src_reg = 1'b1;
        alu_ctl     = ALU_SUB;
        retire      = 1'b1;
        next_state  = S_FETCH;
      end
      S_HALT:   halted = 1'b1;
      default:  next_state = S_HALT;
    endcase
  end

  // Architectural and non-architectural datapath registers, updated per state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= RESET_PC;
      ir      <= 32'd0;
      old_pc  <= 32'd0;
      a       <= 32'd0;
      b       <= 32'd0;
      alu_out <= 32'd0;
      data    <= 32'd0;
    end else begin
      case (state)
        S_FETCH: if (mem_ready) begin
          ir     <= mem_rdata;
          old_pc <= pc;
          pc     <= pc + 32'd4;
        end
        S_DECODE: begin
          a       <= rd1;
          b       <= rd2;
          alu_out <= old_pc + imm_ext;
        end
        S_MEMADR, S_EXECR, S_EXECI: alu_out <= alu_y;
        S_MEMREAD: if (mem_ready) data <= mem_rdata;
        S_JAL: begin
          pc      <= alu_out;
          alu_out <= old_pc + 32'd4;
        end
        S_BRANCH: if (taken) pc <= alu_out;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rv32i_multicycle_core.sv
// Self-checking bench: unified memory model with programmable wait states and
// scoreboards for stores, memory accesses and retire cycles.
module tb_rv32i_multicycle_core;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ready, retire, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] dat;
  } acc_t;

  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;

  logic [31:0] mem [0:255];
  int          wait_n = 0;
  int          wcnt = 0;
  int          cyc = 0;
  int          ret_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  int          ld_ptr = 0;
  logic        acc_on = 1'b0;
  logic        ret_on = 1'b0;
  acc_t        acc_q[$];
  acc_t        st_q[$];
  int          ret_q[$];

  rv32i_multicycle_core #(.RESET_PC(32'h0000_0000)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .pc        (pc),
    .retire    (retire),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];
  assign mem_ready = mem_req && (wcnt == wait_n);

  always @(posedge clk) begin
    if (reset || !mem_req || mem_ready) wcnt <= 0;
    else                                wcnt <= wcnt + 1;
    if (!reset && mem_req && mem_we && mem_ready) mem[mem_addr[9:2]] = mem_wdata;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] s_t(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] b_t(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] j_t(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    acc_t h;
    int   e;
    if (!reset) begin
      if (retire) begin
        ret_cnt++;
        if (ret_on) begin
          e = (ret_q.size() != 0) ? ret_q.pop_front() : -1;
          chk("retire_cyc", cyc, e);
        end
      end
      if (mem_req && mem_we && mem_ready) begin
        h = (st_q.size() != 0) ? st_q.pop_front() : '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        chk("store_addr", mem_addr, h.addr);
        chk("store_data", mem_wdata, h.dat);
      end
      if (acc_on && mem_req) begin
        h = (acc_q.size() != 0) ? acc_q[0] : '{1'b0, 32'hFFFF_FFFF, 32'h0};
        chk("acc_we", {31'd0, mem_we}, {31'd0, h.we});
        chk("acc_addr", mem_addr, h.addr);
        if (h.we) chk("acc_wdata", mem_wdata, h.dat);
        if (mem_ready && acc_q.size() != 0) void'(acc_q.pop_front());
      end
    end
  end

  task automatic emit(input logic [31:0] w);
    mem[ld_ptr] = w;
    ld_ptr++;
  endtask

  task automatic acc(input logic we, input logic [31:0] addr, input logic [31:0] dat);
    acc_q.push_back('{we, addr, dat});
  endtask

  task automatic st(input logic [31:0] addr, input logic [31:0] dat);
    st_q.push_back('{1'b1, addr, dat});
  endtask

  task automatic begin_test(input int w);
    @(negedge clk);
    reset = 1'b1;
    wait_n = w;
    acc_on = 1'b0;
    ret_on = 1'b0;
    acc_q.delete();
    st_q.delete();
    ret_q.delete();
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    ld_ptr = 0;
    @(negedge clk);
    ret_cnt = 0;
  endtask

  task automatic go();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_halt(input string tag);
    int n = 0;
    while (!halted && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, halted}, 32'd1);
  endtask

  task automatic end_test(input string tag);
    chk({tag, "_st_left"}, st_q.size(), 32'd0);
    chk({tag, "_acc_left"}, acc_q.size(), 32'd0);
    chk({tag, "_ret_left"}, ret_q.size(), 32'd0);
  endtask

  initial begin
    // Reset values
    begin_test(0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_retire", {31'd0, retire}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_pc", pc, 32'h0);

    // 1: ALU chain and store, zero wait
    emit(i_t(12'd5, 5'd0, 3'b000, 5'd1, OP_I));
    emit(i_t(12'd7, 5'd0, 3'b000, 5'd2, OP_I));
    emit(r_t(7'h00, 5'd2, 5'd1, 3'b000, 5'd3));
    emit(s_t(12'h100, 5'd3, 5'd0));
    st(32'h100, 32'd12);
    ret_q = '{4, 8, 12, 16};
    ret_on = 1'b1;
    go();
    wait_halt("t1_halt");
    chk("t1_mem100", mem[64], 32'd12);
    chk("t1_retires", ret_cnt, 32'd4);
    end_test("t1");

    // 2: three wait states on every access
    begin_test(3);
    emit(i_t(12'h100, 5'd0, 3'b010, 5'd4, OP_LW));
    emit(s_t(12'h104, 5'd4, 5'd0));
    mem[64] = 32'hDEAD_BEEF;
    acc(1'b0, 32'h0, 32'h0);
    acc(1'b0, 32'h100, 32'h0);
    acc(1'b0, 32'h4, 32'h0);
    acc(1'b1, 32'h104, 32'hDEAD_BEEF);
    acc(1'b0, 32'h8, 32'h0);
    st(32'h104, 32'hDEAD_BEEF);
    ret_q = '{11, 21};
    ret_on = 1'b1;
    acc_on = 1'b1;
    go();
    wait_halt("t2_halt");
    chk("t2_mem104", mem[65], 32'hDEAD_BEEF);
    end_test("t2");

    // 3: counted loop with bne, then a taken beq
    begin_test(0);
    emit(i_t(12'd3, 5'd0, 3'b000, 5'd1, OP_I));
    emit(i_t(12'hFFF, 5'd1, 3'b000, 5'd1, OP_I));
    emit(b_t(13'h1FFC, 5'd0, 5'd1, 3'b001));
    emit(b_t(13'd8, 5'd0, 5'd0, 3'b000));
    acc(1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      acc(1'b0, 32'h4, 32'h0);
      acc(1'b0, 32'h8, 32'h0);
    end
    acc(1'b0, 32'hC, 32'h0);
    acc(1'b0, 32'h14, 32'h0);
    acc_on = 1'b1;
    go();
    wait_halt("t3_halt");
    chk("t3_retires", ret_cnt, 32'd8);
    chk("t3_pc", pc, 32'h18);
    end_test("t3");

    // 4: jal link value and target
    begin_test(0);
    emit(j_t(21'd32, 5'd0));
    mem[8]  = j_t(21'd12, 5'd5);
    mem[11] = s_t(12'h110, 5'd5, 5'd0);
    acc(1'b0, 32'h0, 32'h0);
    acc(1'b0, 32'h20, 32'h0);
    acc(1'b0, 32'h2C, 32'h0);
    acc(1'b1, 32'h110, 32'h24);
    acc(1'b0, 32'h30, 32'h0);
    st(32'h110, 32'h24);
    acc_on = 1'b1;
    go();
    wait_halt("t4_halt");
    chk("t4_mem110", mem[68], 32'h24);
    end_test("t4");

    // 5a: illegal all-zero instruction halts with no further requests
    begin_test(0);
    go();
    wait_halt("t5_halt");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_halt_noreq", {31'd0, mem_req}, 32'd0);
    end
    chk("t5_pc", pc, 32'h4);
    chk("t5_retires", ret_cnt, 32'd0);

    // 5b: reset mid-MEMREAD
    begin_test(3);
    emit(i_t(12'h100, 5'd0, 3'b010, 5'd4, OP_LW));
    go();
    begin
      int   n = 0;
      logic found = 1'b0;
      while (!found && n < 100) begin
        @(negedge clk);
        n++;
        found = mem_req && !mem_we && (mem_addr == 32'h100);
      end
      chk("t5_reach_memread", {31'd0, found}, 32'd1);
      #1 reset = 1'b1;
      #1;
      chk("t5_rst_req", {31'd0, mem_req}, 32'd0);
      chk("t5_rst_pc", pc, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      n = 0;
      found = 1'b0;
      while (!found && n < 20) begin
        @(negedge clk);
        n++;
        found = mem_req;
      end
      chk("t5_refetch_seen", {31'd0, found}, 32'd1);
      chk("t5_refetch_cyc", cyc, 32'd1);
      chk("t5_refetch_addr", mem_addr, 32'h0);
      chk("t5_refetch_we", {31'd0, mem_we}, 32'd0);
    end

    // 6: writes to x0 are dropped
    begin_test(0);
    emit(i_t(12'd9, 5'd0, 3'b000, 5'd0, OP_I));
    emit(s_t(12'h108, 5'd0, 5'd0));
    mem[66] = 32'hFFFF_FFFF;
    st(32'h108, 32'h0);
    go();
    wait_halt("t6_halt");
    chk("t6_mem108", mem[66], 32'h0);
    end_test("t6");

    // 7: sub / slt / or / and / andi with a negative operand
    begin_test(1);
    emit(i_t(12'hFFD, 5'd0, 3'b000, 5'd1, OP_I));
    emit(i_t(12'd5, 5'd0, 3'b000, 5'd2, OP_I));
    emit(r_t(7'h20, 5'd1, 5'd2, 3'b000, 5'd3));
    emit(r_t(7'h00, 5'd2, 5'd1, 3'b010, 5'd4));
    emit(r_t(7'h00, 5'd2, 5'd1, 3'b110, 5'd5));
    emit(r_t(7'h00, 5'd2, 5'd1, 3'b111, 5'd6));
    emit(i_t(12'h0F0, 5'd1, 3'b111, 5'd7, OP_I));
    for (int r = 3; r <= 7; r++) emit(s_t(12'h120 + 12'(4 * (r - 3)), 5'(r), 5'd0));
    st(32'h120, 32'd8);
    st(32'h124, 32'd1);
    st(32'h128, 32'hFFFF_FFFD);
    st(32'h12C, 32'd5);
    st(32'h130, 32'hF0);
    go();
    wait_halt("t7_halt");
    chk("t7_retires", ret_cnt, 32'd12);
    end_test("t7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
